// File: rtl/game_pkg.sv
// Shared encodings for the brick-breaker game-flow controller and its testbench.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        PAUSE = 3'd3,
        LOST  = 3'd4,
        CLEAR = 3'd5,
        OVER  = 3'd6
    } phase_t;

    localparam logic [3:0] KEY_NONE  = 4'd0;
    localparam logic [3:0] KEY_LEFT  = 4'd4;
    localparam logic [3:0] KEY_RIGHT = 4'd6;
    localparam logic [3:0] KEY_START = 4'd10;

    localparam int         BRICK_COUNT = 56;
    localparam logic [2:0] MAX_LEVEL   = 3'd7;

endpackage

// File: rtl/game_sequencer_if.sv
// Signal bundle between the keypad/collision side and the game sequencer.
interface game_sequencer_if;
    import game_pkg::*;

    logic                   tick;
    logic [3:0]             control;
    logic                   ball_lost;
    logic [BRICK_COUNT-1:0] bricks;

    logic                   ball_step;
    logic                   plate_step;
    logic                   ball_init;
    logic                   bricks_init;
    logic                   score_clear;
    logic [2:0]             phase;
    logic [1:0]             lives;
    logic [2:0]             level;
    logic                   game_over;

    modport master (
        output tick, control, ball_lost, bricks,
        input  ball_step, plate_step, ball_init, bricks_init, score_clear,
        input  phase, lives, level, game_over
    );

    modport slave (
        input  tick, control, ball_lost, bricks,
        output ball_step, plate_step, ball_init, bricks_init, score_clear,
        output phase, lives, level, game_over
    );

endinterface

// File: rtl/game_sequencer_step_timer.sv
// Tick-driven modulo counter: emits a one-clock step every `period` unfrozen ticks.
module step_timer (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       freeze,
    input  logic       clear,
    input  logic [7:0] period,
    output logic       step
);

    logic [7:0] cnt_q;

    // >= rather than == so a shortened period never lets the count run past it
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
            step  <= 1'b0;
        end else begin
            step <= 1'b0;
            if (clear) begin
                cnt_q <= '0;
            end else if (tick && !freeze) begin
                if (cnt_q >= period - 8'd1) begin
                    cnt_q <= '0;
                    step  <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: phase FSM, lives/level tracking and tick-derived ball/plate step enables.
module game_sequencer
    import game_pkg::*;
#(
    parameter int BALL_BASE_PERIOD = 50,
    parameter int BALL_PERIOD_DEC  = 5,
    parameter int BALL_MIN_PERIOD  = 10,
    parameter int PLATE_PERIOD     = 10,
    parameter int SERVE_TICKS      = 100,
    parameter int START_LIVES      = 3
) (
    input  logic             clock,
    input  logic             reset,
    game_sequencer_if.slave  bus
);

    // Floor is applied before the subtraction so high levels cannot wrap the period.
    function automatic logic [7:0] ball_period_f(input logic [2:0] lvl);
        logic [7:0] prod;
        logic [7:0] diff;
        prod = 8'(lvl) * 8'(BALL_PERIOD_DEC);
        if (prod >= 8'(BALL_BASE_PERIOD)) return 8'(BALL_MIN_PERIOD);
        diff = 8'(BALL_BASE_PERIOD) - prod;
        return (diff < 8'(BALL_MIN_PERIOD)) ? 8'(BALL_MIN_PERIOD) : diff;
    endfunction

    phase_t      state_q, state_d;
    logic        start_q;
    logic        press;
    logic [1:0]  lives_q;
    logic [2:0]  level_q;
    logic [15:0] serve_cnt;
    logic        bricks_empty;
    logic        serve_last;

    logic        start_game, play_run, serve_done;
    logic        ball_init_d, bricks_init_d, score_clear_d;
    logic        ball_init_q, bricks_init_q, score_clear_q;
    logic [7:0]  ball_period;

    assign press        = (bus.control == KEY_START) && !start_q;
    assign bricks_empty = (bus.bricks == '0);
    assign serve_last   = (serve_cnt == 16'd1);
    assign ball_period  = ball_period_f(level_q);

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (press) state_d = SERVE;
            SERVE:   if (bus.tick && serve_last) state_d = PLAY;
            PLAY: begin
                if (bus.ball_lost)  state_d = LOST;
                else if (bricks_empty) state_d = CLEAR;
                else if (press)     state_d = PAUSE;
            end
            PAUSE:   if (press) state_d = PLAY;
            LOST:    state_d = (lives_q > 2'd1) ? SERVE : OVER;
            CLEAR:   state_d = SERVE;
            OVER:    if (press) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start_game    = (state_q == IDLE) && press;
        ball_init_d   = start_game || (state_q == CLEAR) ||
                        ((state_q == LOST) && (lives_q > 2'd1));
        bricks_init_d = start_game || (state_q == CLEAR);
        score_clear_d = start_game;
        play_run      = (state_q == PLAY) && (state_d == PLAY);
        serve_done    = (state_q == SERVE) && bus.tick && serve_last;
    end

    // Every ball placement (start, life lost, level clear) also restarts the serve hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            start_q       <= 1'b0;
            lives_q       <= '0;
            level_q       <= '0;
            serve_cnt     <= '0;
            ball_init_q   <= 1'b0;
            bricks_init_q <= 1'b0;
            score_clear_q <= 1'b0;
        end else begin
            start_q       <= (bus.control == KEY_START);
            ball_init_q   <= ball_init_d;
            bricks_init_q <= bricks_init_d;
            score_clear_q <= score_clear_d;
            if (start_game) begin
                lives_q <= 2'(START_LIVES);
                level_q <= '0;
            end else if (state_q == LOST) begin
                lives_q <= (lives_q > 2'd1) ? lives_q - 2'd1 : 2'd0;
            end else if ((state_q == CLEAR) && (level_q != MAX_LEVEL)) begin
                level_q <= level_q + 3'd1;
            end
            if (ball_init_d) begin
                serve_cnt <= 16'(SERVE_TICKS);
            end else if ((state_q == SERVE) && bus.tick && (serve_cnt != '0)) begin
                serve_cnt <= serve_cnt - 16'd1;
            end
        end
    end

    step_timer u_ball_timer (
        .clock  (clock),
        .reset  (reset),
        .tick   (bus.tick),
        .freeze (!play_run),
        .clear  (serve_done),
        .period (ball_period),
        .step   (bus.ball_step)
    );

    step_timer u_plate_timer (
        .clock  (clock),
        .reset  (reset),
        .tick   (bus.tick),
        .freeze (!play_run),
        .clear  (serve_done),
        .period (8'(PLATE_PERIOD)),
        .step   (bus.plate_step)
    );

    assign bus.phase       = state_q;
    assign bus.lives       = lives_q;
    assign bus.level       = level_q;
    assign bus.game_over   = (state_q == OVER);
    assign bus.ball_init   = ball_init_q;
    assign bus.bricks_init = bricks_init_q;
    assign bus.score_clear = score_clear_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed + randomized bench for game_sequencer against a tick-counting game model.
module tb_game_sequencer;
    import game_pkg::*;

    localparam int BASE  = 50;
    localparam int DEC   = 5;
    localparam int MINP  = 10;
    localparam int PLATE = 10;
    localparam int SERVE_T = 100;
    localparam int LIVES0  = 3;

    logic clock = 1'b0;
    logic reset;
    logic [55:0] full;

    game_sequencer_if bus ();

    game_sequencer #(
        .BALL_BASE_PERIOD (BASE),
        .BALL_PERIOD_DEC  (DEC),
        .BALL_MIN_PERIOD  (MINP),
        .PLATE_PERIOD     (PLATE),
        .SERVE_TICKS      (SERVE_T),
        .START_LIVES      (LIVES0)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Model: game phase plus ticks counted in PLAY since the last serve.
    int m_phase, m_lives, m_level, m_serve, m_ticks;
    bit m_key;
    bit e_ball, e_plate, e_binit, e_brinit, e_sclr;

    function automatic int exp_period(input int lvl);
        int p;
        p = BASE - lvl * DEC;
        return (p < MINP) ? MINP : p;
    endfunction

    task automatic model_edge(input bit r, input bit t, input int c, input bit l, input bit bz);
        bit press;
        {e_ball, e_plate, e_binit, e_brinit, e_sclr} = '0;
        if (r) begin
            m_phase = 0; m_lives = 0; m_level = 0; m_serve = 0; m_ticks = 0; m_key = 0;
            return;
        end
        press = (c == 10) && !m_key;
        m_key = (c == 10);
        case (m_phase)
            0: if (press) begin
                m_phase = 1; m_lives = LIVES0; m_level = 0; m_serve = SERVE_T;
                e_binit = 1; e_brinit = 1; e_sclr = 1;
            end
            1: if (t) begin
                m_serve--;
                if (m_serve == 0) begin m_phase = 2; m_ticks = 0; end
            end
            2: begin
                if (l) m_phase = 4;
                else if (bz) m_phase = 5;
                else if (press) m_phase = 3;
                else if (t) begin
                    m_ticks++;
                    e_ball  = (m_ticks % exp_period(m_level)) == 0;
                    e_plate = (m_ticks % PLATE) == 0;
                end
            end
            3: if (press) m_phase = 2;
            4: begin
                if (m_lives > 1) begin
                    m_lives--; m_phase = 1; m_serve = SERVE_T; e_binit = 1;
                end else begin
                    m_lives = 0; m_phase = 6;
                end
            end
            5: begin
                if (m_level < 7) m_level++;
                e_brinit = 1; e_binit = 1; m_serve = SERVE_T; m_phase = 1;
            end
            6: if (press) m_phase = 0;
            default: m_phase = 0;
        endcase
    endtask

    task automatic chk(input string tag, input int obs, input int req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, req);
        end
    endtask

    task automatic step(input bit t, input logic [3:0] c, input bit l, input logic [55:0] b);
        logic [13:0] obs, req;
        bus.tick = t; bus.control = c; bus.ball_lost = l; bus.bricks = b;
        @(posedge clock);
        model_edge(reset, t, int'(c), l, (b == '0));
        #1;
        obs = {bus.phase, bus.lives, bus.level, bus.game_over, bus.ball_step,
               bus.plate_step, bus.ball_init, bus.bricks_init, bus.score_clear};
        req = {3'(m_phase), 2'(m_lives), 3'(m_level), (m_phase == 6), e_ball,
               e_plate, e_binit, e_brinit, e_sclr};
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL cycle t=%0t observed=%h expected=%h", $time, obs, req);
        end
    endtask

    function automatic logic [3:0] rnd_key();
        case ($urandom_range(0, 2))
            0:       return KEY_NONE;
            1:       return KEY_LEFT;
            default: return KEY_RIGHT;
        endcase
    endfunction

    function automatic logic [55:0] rnd_bricks();
        logic [63:0] v;
        v = {$urandom, $urandom};
        return v[55:0] | 56'd1;
    endfunction

    task automatic press_start();
        step(0, KEY_START, 0, full);
        step(0, KEY_NONE, 0, full);
    endtask

    task automatic serve_out();
        for (int i = 0; i < 300; i++) begin
            if (bus.phase == 3'd2) break;
            step(1, rnd_key(), 0, full);
        end
        chk("serve_exit", int'(bus.phase), 2);
    endtask

    task automatic ticks_to_ball(output int n);
        n = -1;
        for (int i = 1; i <= 120; i++) begin
            step(1, rnd_key(), 0, full);
            if (bus.ball_step) begin n = i; break; end
        end
    endtask

    initial begin
        int n, seen, pulses;
        full = '1;
        reset = 1'b1;
        bus.tick = 0; bus.control = KEY_NONE; bus.ball_lost = 0; bus.bricks = full;
        step(0, KEY_NONE, 0, full);
        step(1, KEY_START, 1, '0);
        chk("reset_phase", int'(bus.phase), 0);
        reset = 1'b0;

        // Held start key: exactly one press
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step(0, KEY_START, 0, full);
            pulses += int'(bus.ball_init & bus.bricks_init & bus.score_clear);
        end
        step(0, KEY_NONE, 0, full);
        chk("start_pulses", pulses, 1);
        chk("start_phase", int'(bus.phase), 1);
        chk("start_lives", int'(bus.lives), 3);

        // Serve hold of 100 ticks with idle gaps
        for (int k = 1; k <= SERVE_T; k++) begin
            if ($urandom_range(0, 1) == 1) step(0, rnd_key(), 0, full);
            step(1, rnd_key(), 0, full);
            if (k == SERVE_T - 1) chk("serve_99", int'(bus.phase), 1);
        end
        chk("serve_100", int'(bus.phase), 2);

        // Pause does not consume ball ticks
        for (int i = 0; i < 20; i++) step(1, rnd_key(), 0, full);
        press_start();
        chk("pause_enter", int'(bus.phase), 3);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            step(1, rnd_key(), 0, full);
            seen += int'(bus.ball_step | bus.plate_step);
        end
        chk("pause_steps", seen, 0);
        press_start();
        chk("pause_exit", int'(bus.phase), 2);
        ticks_to_ball(n);
        chk("resume_ball", n, 30);

        for (int i = 0; i < 200; i++)
            step($urandom_range(0, 2) == 0, rnd_key(), 0, rnd_bricks());

        // Three lives lost
        step(0, KEY_NONE, 1, full);
        chk("lost_phase", int'(bus.phase), 4);
        step(0, KEY_NONE, 0, full);
        chk("lost1_lives", int'(bus.lives), 2);
        chk("lost1_binit", int'(bus.ball_init), 1);
        serve_out();
        step(0, KEY_NONE, 1, full);
        step(0, KEY_NONE, 0, full);
        chk("lost2_lives", int'(bus.lives), 1);
        serve_out();
        step(0, KEY_NONE, 1, full);
        step(0, KEY_NONE, 0, full);
        chk("over_phase", int'(bus.phase), 6);
        chk("over_flag", int'(bus.game_over), 1);
        chk("over_lives", int'(bus.lives), 0);
        step(1, KEY_NONE, 1, '0);
        press_start();
        chk("over_to_idle", int'(bus.phase), 0);

        // Level clears up to and past the top level
        press_start();
        serve_out();
        for (int lv = 1; lv <= 8; lv++) begin
            step(0, KEY_NONE, 0, '0);
            step(0, KEY_NONE, 0, full);
            chk("clear_level", int'(bus.level), (lv > 7) ? 7 : lv);
            chk("clear_bricks_init", int'(bus.bricks_init & bus.ball_init), 1);
            serve_out();
            ticks_to_ball(n);
            chk("clear_period", n, exp_period((lv > 7) ? 7 : lv));
        end

        // ball_lost beats bricks==0
        step(0, KEY_NONE, 1, '0);
        chk("prio_phase", int'(bus.phase), 4);
        step(0, KEY_NONE, 0, full);
        chk("prio_level", int'(bus.level), 7);

        // Reset while paused
        serve_out();
        press_start();
        chk("pre_reset_pause", int'(bus.phase), 3);
        reset = 1'b1;
        step(1, KEY_START, 1, '0);
        chk("reset_pause_phase", int'(bus.phase), 0);
        chk("reset_pause_level", int'(bus.level), 0);
        reset = 1'b0;

        // Random soak
        for (int i = 0; i < 6000; i++) begin
            logic [3:0] c;
            c = ($urandom_range(0, 15) == 0) ? KEY_START : rnd_key();
            step($urandom_range(0, 1) == 1, c, $urandom_range(0, 63) == 0,
                 ($urandom_range(0, 127) == 0) ? 56'd0 : rnd_bricks());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
